// File: rtl/game_pkg.sv
// Shared types and constants for the rock-dodging game: state encoding,
// default end-of-game thresholds and the 5-bit count type used by the display.
package game_pkg;

  localparam logic [1:0] GS_IDLE = 2'b00;
  localparam logic [1:0] GS_PLAY = 2'b01;
  localparam logic [1:0] GS_WIN  = 2'b10;
  localparam logic [1:0] GS_LOSE = 2'b11;

  localparam int DEF_WIN_SCORE  = 15;
  localparam int DEF_MAX_MISSES = 15;

  typedef logic [4:0] count_t;

  localparam count_t COUNT_MAX = 5'd31;

  typedef enum logic [1:0] {
    ST_IDLE = GS_IDLE,
    ST_PLAY = GS_PLAY,
    ST_WIN  = GS_WIN,
    ST_LOSE = GS_LOSE
  } state_t;

  function automatic count_t sat_inc(input count_t v, input logic inc);
    return (inc && (v != COUNT_MAX)) ? v + 5'd1 : v;
  endfunction

endpackage

// File: rtl/game_ctrl_timer.sv
// Millisecond interval timer: counts enabled ticks and flags the tick that
// completes LIMIT of them, then restarts from zero. clear wins over counting.
module ms_interval_timer #(
  parameter int LIMIT = 500
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  input  logic tick,
  output logic done
);

  localparam int W = $clog2(LIMIT);
  localparam logic [W-1:0] LAST = W'(LIMIT - 1);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  // done is the completing tick itself so the consumer can act on the same edge
  always_comb begin
    count_d = count_q;
    done    = 1'b0;
    if (clear) begin
      count_d = '0;
    end else if (enable && tick) begin
      if (count_q == LAST) begin
        count_d = '0;
        done    = 1'b1;
      end else begin
        count_d = count_q + W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/game_ctrl.sv
// Game sequencer: IDLE -> PLAY -> WIN/LOSE flow, score/miss counting and spawn pacing.
// Optional pause support is built when GAME_PAUSE_EN is defined.
module game_ctrl
  import game_pkg::*;
#(
  parameter int WIN_SCORE  = DEF_WIN_SCORE,
  parameter int MAX_MISSES = DEF_MAX_MISSES,
  parameter int SPAWN_MS   = 500,
  parameter int HOLD_MS    = 3000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       clk_1ms,
  input  logic       start,
  input  logic       hit,
  input  logic       miss,
  input  logic       pause,
  output logic [1:0] game_state,
  output logic [4:0] score,
  output logic [4:0] misses,
  output logic       spawn,
  output logic       paused
);

  localparam count_t WIN_Q  = count_t'(WIN_SCORE);
  localparam count_t MISS_Q = count_t'(MAX_MISSES);

  state_t state_q, state_d;
  count_t score_q, score_d;
  count_t misses_q, misses_d;
  logic   start_prev_q;
  logic   spawn_q, spawn_d;
  logic   start_edge;
  logic   freeze;
  logic   spawn_done, hold_done;
  logic   in_play, in_hold;

  assign start_edge = start && !start_prev_q;
  assign in_play    = (state_q == ST_PLAY);
  assign in_hold    = (state_q == ST_WIN) || (state_q == ST_LOSE);

`ifdef GAME_PAUSE_EN
  logic paused_q;
  logic paused_d;

  assign freeze   = pause && in_play;
  assign paused_d = pause && (state_d == ST_PLAY);

  always_ff @(posedge clk) begin
    if (reset) begin
      paused_q <= 1'b0;
    end else begin
      paused_q <= paused_d;
    end
  end

  assign paused = paused_q;
`else
  logic unused_pause;

  assign unused_pause = pause;
  assign freeze       = 1'b0;
  assign paused       = 1'b0;
`endif

  ms_interval_timer #(.LIMIT(SPAWN_MS)) u_spawn_timer (
    .clk    (clk),
    .reset  (reset),
    .clear  (!in_play),
    .enable (in_play && !freeze),
    .tick   (clk_1ms),
    .done   (spawn_done)
  );

  ms_interval_timer #(.LIMIT(HOLD_MS)) u_hold_timer (
    .clk    (clk),
    .reset  (reset),
    .clear  (!in_hold),
    .enable (in_hold),
    .tick   (clk_1ms),
    .done   (hold_done)
  );

  always_comb begin
    state_d  = state_q;
    score_d  = score_q;
    misses_d = misses_q;
    case (state_q)
      ST_IDLE: begin
        score_d  = '0;
        misses_d = '0;
        if (start_edge) state_d = ST_PLAY;
      end
      ST_PLAY: begin
        if (!freeze) begin
          score_d  = sat_inc(score_q, hit);
          misses_d = sat_inc(misses_q, miss);
          // thresholds are judged on the post-increment values; a win outranks a loss
          if (score_d >= WIN_Q) begin
            state_d = ST_WIN;
          end else if (misses_d >= MISS_Q) begin
            state_d = ST_LOSE;
          end
        end
      end
      ST_WIN, ST_LOSE: begin
        if (hold_done || start_edge) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    spawn_d = spawn_done && (state_d == ST_PLAY);
  end

  // start_prev_q resets high so a button already held through reset must be re-pressed
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      score_q      <= '0;
      misses_q     <= '0;
      start_prev_q <= 1'b1;
      spawn_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      score_q      <= score_d;
      misses_q     <= misses_d;
      start_prev_q <= start;
      spawn_q      <= spawn_d;
    end
  end

  assign game_state = state_q;
  assign score      = score_q;
  assign misses     = misses_q;
  assign spawn      = spawn_q;

endmodule
